fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_out_stage.sv | 56 +++++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam int unsigned INSN_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'd0;
    localparam logic [31:0] DEFAULT_PROG_END = 32'd40;

endpackage

// File: rtl/fetch_out_stage.sv
// Single-entry valid/ready output register between fetch and decode.
module fetch_out_stage
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_i,
    input  logic                     flush_i,
    input  logic [DATA_WIDTH-1:0]    instr_i,
    input  logic [ADDRESS_WIDTH-1:0] pc_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [ADDRESS_WIDTH-1:0] pc_o
);

    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    instr_q, instr_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;

    // Flush wins over load; an accepted word with no replacement empties the slot.
    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            instr_d = instr_i;
            pc_d    = pc_i;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign valid_o = valid_q;
    assign instr_o = instr_q;
    assign pc_o    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Program counter, fetch FSM and output stage feeding decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirect raises a sticky fault and halts.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH    = 32,
    parameter int unsigned            ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC    = ADDRESS_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [ADDRESS_WIDTH-1:0] PROG_END    = ADDRESS_WIDTH'(DEFAULT_PROG_END)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_instr,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_instr,
    output logic [ADDRESS_WIDTH-1:0] out_pc,
    output logic                     halted,
    output logic                     fault
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic                     load, flush, slot_free;
    logic [ADDRESS_WIDTH-1:0] aligned_target;
    logic                     fault_d;
    logic                     fault_q;

    assign slot_free      = !out_valid || out_ready;
    assign aligned_target = redirect_pc & ~ADDRESS_WIDTH'(3);

    // Redirect takes priority over both fetch and the end-of-program check.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN, HALT: begin
                if (redirect_valid) begin
                    flush = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = HALT;
                    end else begin
                        pc_d    = redirect_pc;
                        state_d = RUN;
                    end
`else
                    pc_d    = aligned_target;
                    state_d = RUN;
`endif
                end else if (state_q == RUN) begin
                    if (pc_q == PROG_END) begin
                        state_d = HALT;
                    end else if (slot_free) begin
                        load = 1'b1;
                        pc_d = pc_q + ADDRESS_WIDTH'(INSN_BYTES);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    fetch_out_stage #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_out_stage (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .flush_i(flush),
        .instr_i(imem_instr),
        .pc_i   (pc_q),
        .ready_i(out_ready),
        .valid_o(out_valid),
        .instr_o(out_instr),
        .pc_o   (out_pc)
    );

    assign imem_addr = pc_q;
    assign halted    = (state_q == HALT);
`ifdef FETCH_MISALIGN_CHECK_EN
    assign fault     = fault_q;
`else
    assign fault     = 1'b0 & fault_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;
    logic        fault;

    logic [31:0] mem [0:255];
    int          checkCount = 0;
    int          failCount  = 0;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .halted        (halted),
        .fault         (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_instr = mem[imem_addr[9:2]];

    function automatic logic [31:0] wordAt(input logic [31:0] addr);
        return 32'hA500_0000 | (addr >> 2);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Drive inputs, then advance through one rising edge to the following falling edge.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rpc, input logic rdy);
        start          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        out_ready      = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
        rst_n          = 1'b0;
        start          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;
        repeat (2) @(negedge clk);

        checkOutput("rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("rst_addr", imem_addr, 32'd0);
        checkOutput("rst_out_pc", out_pc, 32'd0);
        checkOutput("rst_out_instr", out_instr, 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("start_no_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("start_not_halted", {31'd0, halted}, 32'd0);

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("stream_valid%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stream_pc%0d", i), out_pc, 32'(4 * i));
            checkOutput($sformatf("stream_instr%0d", i), out_instr, wordAt(32'(4 * i)));
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        end
        checkOutput("end_halted", {31'd0, halted}, 32'd1);
        checkOutput("end_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("end_addr", imem_addr, 32'd40);

        applyStimulus(1'b1, 1'b0, 32'd0, 1'b1);
        checkOutput("halt_start_ignored", {31'd0, halted}, 32'd1);
        checkOutput("halt_start_no_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("halt_start_addr", imem_addr, 32'd40);

        applyStimulus(1'b0, 1'b1, 32'd0, 1'b0);
        checkOutput("halt_redir_run", {31'd0, halted}, 32'd0);
        checkOutput("halt_redir_flush", {31'd0, out_valid}, 32'd0);
        checkOutput("halt_redir_addr", imem_addr, 32'd0);

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("refetch_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("refetch_pc", out_pc, 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
            checkOutput($sformatf("stall_valid%0d", i), {31'd0, out_valid}, 32'd1);
            checkOutput($sformatf("stall_pc%0d", i), out_pc, 32'd0);
            checkOutput($sformatf("stall_instr%0d", i), out_instr, wordAt(32'd0));
            checkOutput($sformatf("stall_addr%0d", i), imem_addr, 32'd4);
        end

        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("unstall_pc", out_pc, 32'd4);
        checkOutput("unstall_instr", out_instr, wordAt(32'd4));
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("pre_redir_pc", out_pc, 32'd8);
        checkOutput("pre_redir_addr", imem_addr, 32'd12);

        applyStimulus(1'b0, 1'b1, 32'h10, 1'b1);
        checkOutput("redir_flush", {31'd0, out_valid}, 32'd0);
        checkOutput("redir_addr", imem_addr, 32'h10);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("redir_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("redir_pc", out_pc, 32'h10);
        checkOutput("redir_instr", out_instr, wordAt(32'h10));

        applyStimulus(1'b0, 1'b1, 32'h6, 1'b1);
`ifdef FETCH_MISALIGN_CHECK_EN
        checkOutput("mis_fault", {31'd0, fault}, 32'd1);
        checkOutput("mis_halted", {31'd0, halted}, 32'd1);
        checkOutput("mis_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mis_addr", imem_addr, 32'h14);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("mis_fault_sticky", {31'd0, fault}, 32'd1);
        checkOutput("mis_halt_hold", {31'd0, halted}, 32'd1);
`else
        checkOutput("mis_fault", {31'd0, fault}, 32'd0);
        checkOutput("mis_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mis_addr", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
        checkOutput("mis_aligned_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("mis_aligned_pc", out_pc, 32'h4);
        checkOutput("mis_fault_low", {31'd0, fault}, 32'd0);
`endif

        applyStimulus(1'b0, 1'b1, 32'h20, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0);
        checkOutput("pre_reset_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("pre_reset_pc", out_pc, 32'h20);

        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("async_rst_halted", {31'd0, halted}, 32'd0);
        checkOutput("async_rst_fault", {31'd0, fault}, 32'd0);
        checkOutput("async_rst_addr", imem_addr, 32'd0);
        checkOutput("async_rst_out_pc", out_pc, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checkCount, failCount);
        $finish;
    end

endmodule
